// File: rtl/rob_pkg.sv
// Shared constants and entry layout for the reorder/retire buffer.
package rob_pkg;

  localparam int ROB_DEPTH  = 16;
  localparam int ROB_TAG_W  = $clog2(ROB_DEPTH);
  localparam int ROB_PREG_W = 5;
  localparam int ROB_AREG_W = 5;

  localparam logic [ROB_PREG_W-1:0] PREG_ZERO = '0;

  typedef struct packed {
    logic                  valid;
    logic                  done;
    logic                  has_rd;
    logic [ROB_AREG_W-1:0] rd;
    logic [ROB_PREG_W-1:0] prd;
    logic [ROB_PREG_W-1:0] old_prd;
  } rob_entry_t;

endpackage

// File: rtl/rob_ptr.sv
// Wrapping TAG_W-bit pointer; clear takes priority over increment.
module rob_ptr #(
  parameter int TAG_W = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [TAG_W-1:0] ptr_o
);

  logic [TAG_W-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr_i)      ptr_d = '0;
    else if (inc_i) ptr_d = ptr_q + TAG_W'(1);
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/reorder_retire.sv
// In-order retirement buffer: records renamed instructions, marks them done on
// CDB writeback and retires oldest-first, returning old mappings to the free list.
module reorder_retire
  import rob_pkg::*;
#(
  parameter int DEPTH  = ROB_DEPTH,
  parameter int PREG_W = ROB_PREG_W,
  parameter int AREG_W = ROB_AREG_W,
  parameter int TAG_W  = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              flush_i,
  input  logic              alloc_valid_i,
  output logic              alloc_ready_o,
  input  logic              alloc_has_rd_i,
  input  logic [AREG_W-1:0] alloc_rd_i,
  input  logic [PREG_W-1:0] alloc_prd_i,
  input  logic [PREG_W-1:0] alloc_old_prd_i,
  output logic [TAG_W-1:0]  alloc_tag_o,
  input  logic              cdb_en_i,
  input  logic [TAG_W-1:0]  cdb_tag_i,
  output logic              retire_valid_o,
  output logic [AREG_W-1:0] retire_rd_o,
  output logic [PREG_W-1:0] retire_prd_o,
  output logic              free_en_o,
  output logic [PREG_W-1:0] free_addr_o,
  output logic [TAG_W:0]    count_o,
  output logic              empty_o,
  output logic              full_o
);

  localparam logic [TAG_W:0] FULL_COUNT = DEPTH[TAG_W:0];

  rob_entry_t entries_q [DEPTH];
  rob_entry_t entries_d [DEPTH];

  logic [TAG_W:0]    count_q, count_d;
  logic [TAG_W-1:0]  head, tail;
  logic              alloc_fire, wb_fire, retire_fire;
  rob_entry_t        head_entry;

  logic              retire_valid_q, retire_valid_d;
  logic [AREG_W-1:0] retire_rd_q, retire_rd_d;
  logic [PREG_W-1:0] retire_prd_q, retire_prd_d;
  logic              free_en_q, free_en_d;
  logic [PREG_W-1:0] free_addr_q, free_addr_d;

  assign full_o        = (count_q == FULL_COUNT);
  assign empty_o       = (count_q == '0);
  assign alloc_ready_o = !full_o;
  assign alloc_tag_o   = tail;
  assign count_o       = count_q;
  assign head_entry    = entries_q[head];

  // Flush suppresses every event; a writeback aimed at the slot being allocated loses.
  assign alloc_fire  = !flush_i && alloc_valid_i && alloc_ready_o;
  assign retire_fire = !flush_i && head_entry.valid && head_entry.done;
  assign wb_fire     = !flush_i && cdb_en_i && entries_q[cdb_tag_i].valid &&
                       !(alloc_fire && (cdb_tag_i == tail));

  rob_ptr #(.TAG_W(TAG_W)) u_head (
    .clk_i(clk_i), .reset_i(reset_i), .clr_i(flush_i), .inc_i(retire_fire), .ptr_o(head)
  );

  rob_ptr #(.TAG_W(TAG_W)) u_tail (
    .clk_i(clk_i), .reset_i(reset_i), .clr_i(flush_i), .inc_i(alloc_fire), .ptr_o(tail)
  );

  always_comb begin
    entries_d = entries_q;
    if (flush_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_d[i].valid = 1'b0;
        entries_d[i].done  = 1'b0;
      end
    end else begin
      if (wb_fire)     entries_d[cdb_tag_i].done = 1'b1;
      if (retire_fire) entries_d[head].valid     = 1'b0;
      if (alloc_fire) begin
        entries_d[tail].valid   = 1'b1;
        entries_d[tail].done    = 1'b0;
        entries_d[tail].has_rd  = alloc_has_rd_i;
        entries_d[tail].rd      = alloc_rd_i;
        entries_d[tail].prd     = alloc_prd_i;
        entries_d[tail].old_prd = alloc_old_prd_i;
      end
    end
  end

  always_comb begin
    count_d = count_q;
    if (flush_i)                         count_d = '0;
    else if (alloc_fire && !retire_fire) count_d = count_q + (TAG_W+1)'(1);
    else if (!alloc_fire && retire_fire) count_d = count_q - (TAG_W+1)'(1);
  end

  // Retire outputs are zero whenever nothing retires so idle cycles stay clean.
  always_comb begin
    retire_valid_d = retire_fire;
    retire_rd_d    = '0;
    retire_prd_d   = '0;
    free_en_d      = 1'b0;
    free_addr_d    = '0;
    if (retire_fire) begin
      retire_rd_d  = head_entry.rd;
      retire_prd_d = head_entry.prd;
      free_en_d    = head_entry.has_rd && (head_entry.old_prd != PREG_ZERO);
      free_addr_d  = head_entry.old_prd;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
      count_q        <= '0;
      retire_valid_q <= 1'b0;
      retire_rd_q    <= '0;
      retire_prd_q   <= '0;
      free_en_q      <= 1'b0;
      free_addr_q    <= '0;
    end else begin
      entries_q      <= entries_d;
      count_q        <= count_d;
      retire_valid_q <= retire_valid_d;
      retire_rd_q    <= retire_rd_d;
      retire_prd_q   <= retire_prd_d;
      free_en_q      <= free_en_d;
      free_addr_q    <= free_addr_d;
    end
  end

  assign retire_valid_o = retire_valid_q;
  assign retire_rd_o    = retire_rd_q;
  assign retire_prd_o   = retire_prd_q;
  assign free_en_o      = free_en_q;
  assign free_addr_o    = free_addr_q;

endmodule

// File: doc/reorder_retire.md
# reorder_retire

In-order retirement buffer that closes the loop opened by the rename stage. Rename allocates a new physical register per instruction; this block records each renamed instruction in program order, marks it done on common-data-bus writeback, and retires it oldest-first. At retirement it returns the instruction's previous physical mapping to the free list and publishes the committed architectural-to-physical mapping.

## Interface
- DEPTH, 16, entry count; power of two, 4..32
- PREG_W, 5, physical register address width
- AREG_W, 5, architectural register address width
- TAG_W, $clog2(DEPTH), entry tag width
- clk_i  in  1  clock, rising edge
- reset_i  in  1  asynchronous, active-low reset
- flush_i  in  1  discard all entries (synchronous)
- alloc_valid_i  in  1  rename presents an instruction
- alloc_ready_o  out  1  buffer can accept; equals !full_o
- alloc_has_rd_i  in  1  instruction writes a destination
- alloc_rd_i  in  AREG_W  architectural destination
- alloc_prd_i  in  PREG_W  newly allocated physical destination
- alloc_old_prd_i  in  PREG_W  previous mapping of alloc_rd_i, freed at retire
- alloc_tag_o  out  TAG_W  tail index; combinational, given to the instruction as its tag
- cdb_en_i  in  1  writeback valid
- cdb_tag_i  in  TAG_W  tag of completing instruction
- retire_valid_o  out  1  one instruction retired (registered pulse)
- retire_rd_o  out  AREG_W  committed architectural register
- retire_prd_o  out  PREG_W  committed physical register
- free_en_o  out  1  free-list push strobe
- free_addr_o  out  PREG_W  physical register returned to the free list
- count_o  out  TAG_W+1  occupied entries
- empty_o / full_o  out  1  count_o==0 / count_o==DEPTH

## Operation
- Entry fields: valid, done, has_rd, rd, prd, old_prd. head, tail: TAG_W bits, wrap modulo DEPTH. count: TAG_W+1 bits.
- Allocate: fires when alloc_valid_i && alloc_ready_o. Writes the entry at tail with valid=1, done=0. Advances tail.
- Writeback: fires when cdb_en_i is high and entry[cdb_tag_i].valid. Sets done=1. A writeback to an invalid entry is ignored. A writeback to the tag being allocated in the same cycle is ignored; the allocate wins.
- Retire: fires when entry[head].valid && entry[head].done. Clears valid and advances head. Retires at most one entry per cycle.
  - Registers retire_valid_o=1, retire_rd_o=rd, retire_prd_o=prd.
  - Registers free_en_o = has_rd && old_prd!=0, with free_addr_o=old_prd. Physical register 0 is never freed.
  - Entries with no destination retire with free_en_o=0.
- count_o update: allocate alone gives +1; retire alone gives −1; both or neither leave it unchanged.
- alloc_ready_o does not account for a same-cycle retire. A full buffer refuses the allocate even while it retires.
- Flush: highest priority. Clears all valid bits, sets head=tail=0 and count=0, and ignores allocate, writeback and retire in that cycle. Retire outputs are 0 in the following cycle.
- Reset (reset_i low, any time including mid-operation): all valid/done=0, head=tail=count=0. All registered outputs go to 0: retire_valid_o, retire_rd_o, retire_prd_o, free_en_o, free_addr_o. Combinational outputs after reset: alloc_ready_o=1, empty_o=1, full_o=0, alloc_tag_o=0.

## Timing
- Allocate at edge N. The earliest writeback is at edge N+1. The earliest retire is at edge N+2, with retire_valid_o and free_en_o high for the cycle after that edge.
- Writeback to the current head at edge M gives a retire at edge M+1. There is no same-edge bypass from CDB to retire.
- retire_valid_o and free_en_o are single-cycle pulses. A continuous run of done entries retires one per cycle back-to-back.
- alloc_tag_o, alloc_ready_o, empty_o, full_o and count_o reflect state after the last edge.
- Wrap-around: tail DEPTH−1 → 0, and likewise head. full_o is derived from count, never from pointer equality.

## Structure
- Shared package rob_pkg: DEPTH/TAG_W constants, the entry struct typedef, and PREG_ZERO = 0.
- One sub-module, rob_ptr: a wrapping TAG_W-bit pointer with inc and clr inputs, instantiated for head and tail.
- The entry array and count logic live in reorder_retire itself.

## Test plan
- Reset then single op:
  - Stimulus: release reset; allocate rd=3, prd=7, old=3 (tag 0); CDB tag 0 one cycle later.
  - Response: retire_valid_o pulse with rd=3, prd=7, free_en_o=1, free_addr_o=3; count_o returns to 0.
- Out-of-order completion:
  - Stimulus: allocate tags 0,1,2; CDB order 2,1,0.
  - Response: no retire until tag 0 is done, then three consecutive retire pulses in order 0,1,2.
- Full and wrap-around:
  - Stimulus: allocate 16 entries.
  - Response: full_o=1 and alloc_ready_o=0; a 17th alloc_valid_i is refused.
  - Stimulus: complete tag 0.
  - Response: one retire; next allocate gets tag 0 with tail wrapped; count_o stays 16.
- Zero and no-destination:
  - Stimulus: entry with old_prd=0; entry with has_rd=0.
  - Response: both give retire_valid_o=1 with free_en_o=0.
- Flush and async reset:
  - Stimulus: 5 pending entries; flush_i for one cycle.
  - Response: count_o=0, empty_o=1, later CDB to old tags ignored.
  - Stimulus: assert reset_i low mid-retire-burst.
  - Response: retire_valid_o and free_en_o drop immediately, without waiting for a clock edge.
